// File: rtl/pps_period_counter.sv
// PPS period counter: measures CLK33 cycles between accepted PPS edges, counts seconds,
// tracks lock/missing health and issues a one-cycle PPS1 trigger at a programmable offset.
//   state      | meaning
//   ST_IDLE    | out of reset, waiting for the first PPS edge
//   ST_LOCKED  | edges arriving; holdoff filters glitches, trigger armed
//   ST_MISSING | no accepted edge for TIMEOUT cycles; next edge relocks
module pps_period_counter #(
  parameter int CNT_WIDTH = 26,
  parameter int HOLDOFF   = 30_000_000,
  parameter int TIMEOUT   = 36_000_000
) (
  input  logic                 clk33_i,
  input  logic                 rst_n_i,
  input  logic                 pps_i,
  input  logic                 en_i,
  input  logic                 disable_i,
  input  logic [CNT_WIDTH-1:0] offset_i,
  output logic                 trig_o,
  output logic [CNT_WIDTH-1:0] period_o,
  output logic                 period_valid_o,
  output logic [31:0]          sec_count_o,
  output logic                 locked_o,
  output logic                 missing_o,
  output logic                 glitch_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_MISSING = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH:0]   HOLDOFF_C  = (CNT_WIDTH+1)'(HOLDOFF);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_M1 = CNT_WIDTH'(TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic                   pps_q;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   period_q, period_d;
  logic                   period_valid_q, period_valid_d;
  logic [31:0]            sec_q, sec_d;
  logic                   glitch_q, glitch_d;
  logic                   trig_q, trig_d;

  logic                   edge_w;
  logic                   accept;
  logic [CNT_WIDTH:0]     cnt_inc;

  assign edge_w  = pps_i & ~pps_q;
  // One extra bit so cnt+1 never wraps in the holdoff compare.
  assign cnt_inc = {1'b0, cnt_q} + (CNT_WIDTH+1)'(1);

  always_comb begin
    state_d        = state_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    glitch_d       = 1'b0;
    sec_d          = sec_q;
    accept         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (edge_w) begin
          accept  = 1'b1;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (edge_w) begin
          if (cnt_inc >= HOLDOFF_C) begin
            accept         = 1'b1;
            period_d       = cnt_inc[CNT_WIDTH-1:0];
            period_valid_d = 1'b1;
          end else begin
            glitch_d = 1'b1;
          end
        end else if (cnt_q == TIMEOUT_M1) begin
          state_d = ST_MISSING;
        end
      end
      ST_MISSING: begin
        if (edge_w) begin
          accept  = 1'b1;
          state_d = ST_LOCKED;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      sec_d = sec_q + 32'd1;
      cnt_d = '0;
    end else if (&cnt_q) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_inc[CNT_WIDTH-1:0];
    end

    trig_d = (state_q == ST_LOCKED) & en_i & ~disable_i & (cnt_q == offset_i);
  end

  always_ff @(posedge clk33_i) begin
    if (!rst_n_i) begin
      state_q        <= ST_IDLE;
      pps_q          <= 1'b0;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      sec_q          <= '0;
      glitch_q       <= 1'b0;
      trig_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      pps_q          <= pps_i;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      sec_q          <= sec_d;
      glitch_q       <= glitch_d;
      trig_q         <= trig_d;
    end
  end

  assign trig_o         = trig_q;
  assign period_o       = period_q;
  assign period_valid_o = period_valid_q;
  assign sec_count_o    = sec_q;
  assign locked_o       = (state_q == ST_LOCKED);
  assign missing_o      = (state_q == ST_MISSING);
  assign glitch_o       = glitch_q;

endmodule
